// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-addressed load/store at a time and
// answers after a fixed latency over a valid/ready response channel.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          in_range;
    logic          access;
    logic [AW-1:0] idx;

    logic [31:0] mem [DEPTH];

    // Full 32-bit compare so high address bits never alias into the array.
    assign in_range  = (addr_q < DEPTH_W);
    assign idx       = addr_q[AW-1:0];
    assign access    = (state == WAIT) && (cnt == '0);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt     <= CNT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= !in_range;
                        resp_rdata <= (in_range && !we_q) ? mem[idx] : 32'h0;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; clearing it would need a write port per
    // word, and software must not rely on power-up contents anyway.
    always_ff @(posedge clk) begin
        if (access && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
